// File: rtl/snake_pkg.sv
// Shared types and screen geometry for the snake game blocks.
// Also holds the button-arbitration and direction helpers.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } btn_req_t;

    localparam int DEF_SCREEN_WIDTH     = 640;
    localparam int DEF_SCREEN_HEIGHT    = 480;
    localparam int DEF_BORDER_THICKNESS = 20;
    localparam int DEF_STEP             = 10;
    localparam int COORD_W              = 12;

    // Priority up > down > left > right; valid is low when nothing is pressed.
    function automatic btn_req_t pick_button(input logic up, input logic down,
                                             input logic left, input logic right);
        btn_req_t req;
        req.valid = up | down | left | right;
        if (up) begin
            req.dir = DIR_UP;
        end else if (down) begin
            req.dir = DIR_DOWN;
        end else if (left) begin
            req.dir = DIR_LEFT;
        end else begin
            req.dir = DIR_RIGHT;
        end
        return req;
    endfunction

    function automatic dir_e reverse_dir(input dir_e d);
        dir_e r;
        case (d)
            DIR_RIGHT: r = DIR_LEFT;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            default:   r = DIR_RIGHT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_head_if.sv
// Bundle of buttons, score, VGA scan coordinate and head outputs.
// The game logic is the slave; the surrounding system (or bench) is the master.
interface snake_head_if;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic [7:0]  score;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] snake_x;
    logic [11:0] snake_y;
    logic [11:0] snake_size;
    logic        game_over;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, score, x, y,
        input  snake_x, snake_y, snake_size, game_over, vga_r, vga_g, vga_b
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, score, x, y,
        output snake_x, snake_y, snake_size, game_over, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/snake_tick_gen.sv
// Game tick generator: period shrinks with score (clamped at MAX_LEVEL),
// counter runs only while enabled and the tick fires on its last count.
module snake_tick_gen #(
    parameter int TICK_CYCLES    = 5_000_000,
    parameter int SPEEDUP_CYCLES = 500_000,
    parameter int MAX_LEVEL      = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [7:0] score_i,
    output logic       tick_o
);

    localparam int MIN_PERIOD = TICK_CYCLES - MAX_LEVEL * SPEEDUP_CYCLES;

    if (MIN_PERIOD < 2) begin : g_period_check
        $error("snake_tick_gen: fastest tick period must be at least 2 clocks");
    end

    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] level_s;
    logic [31:0] period_s;

    // Current period from the clamped score level.
    always_comb begin
        if (32'(score_i) > 32'(MAX_LEVEL)) begin
            level_s = 32'(MAX_LEVEL);
        end else begin
            level_s = 32'(score_i);
        end
        period_s = 32'(TICK_CYCLES) - level_s * 32'(SPEEDUP_CYCLES);
    end

    // ">=" so a mid-count drop in period fires on the next cycle instead of overrunning.
    assign tick_o = enable_i && (count_q >= (period_s - 32'd1));

    // Next count: held at zero when disabled, wraps on a tick.
    always_comb begin
        count_d = count_q;
        if (!enable_i) begin
            count_d = 32'd0;
        end else if (tick_o) begin
            count_d = 32'd0;
        end else begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/snake_head.sv
// Snake head movement controller: button-driven direction, tick-paced grid
// movement with border collision, and the green head pixel for the VGA mixer.
module snake_head
    import snake_pkg::*;
#(
    parameter int SCREEN_WIDTH     = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT    = DEF_SCREEN_HEIGHT,
    parameter int BORDER_THICKNESS = DEF_BORDER_THICKNESS,
    parameter int STEP             = DEF_STEP,
    parameter int TICK_CYCLES      = 5_000_000,
    parameter int SPEEDUP_CYCLES   = 500_000,
    parameter int MAX_LEVEL        = 8
) (
    input logic         CLOCK_50,
    input logic         reset_n,
    snake_head_if.slave bus
);

    localparam logic [11:0] START_X = 12'(((SCREEN_WIDTH / 2) / STEP) * STEP);
    localparam logic [11:0] START_Y = 12'(((SCREEN_HEIGHT / 2) / STEP) * STEP);
    localparam logic [12:0] STEP13  = 13'(STEP);
    localparam logic [12:0] MIN_POS = 13'(BORDER_THICKNESS);
    localparam logic [13:0] MAX_X_END = 14'(SCREEN_WIDTH - BORDER_THICKNESS);
    localparam logic [13:0] MAX_Y_END = 14'(SCREEN_HEIGHT - BORDER_THICKNESS);

    logic [1:0]  rst_sync_q;
    logic        fsm_rst_n_s;
    state_e      state_q;
    dir_e        dir_q;
    dir_e        pending_q;
    logic [11:0] snake_x_q;
    logic [11:0] snake_y_q;
    logic        game_over_q;

    btn_req_t    req_s;
    logic        tick_s;
    logic [12:0] next_x_s;
    logic [12:0] next_y_s;
    logic        legal_s;
    logic        inside_s;

    // Assert asynchronously, release after two clock edges.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign fsm_rst_n_s = rst_sync_q[1];

    snake_tick_gen #(
        .TICK_CYCLES   (TICK_CYCLES),
        .SPEEDUP_CYCLES(SPEEDUP_CYCLES),
        .MAX_LEVEL     (MAX_LEVEL)
    ) u_tick_gen (
        .clk_i   (CLOCK_50),
        .rst_ni  (fsm_rst_n_s),
        .enable_i(state_q == ST_RUN),
        .score_i (bus.score),
        .tick_o  (tick_s)
    );

    // Candidate position one step along pending; 13 bits so stepping below 0 stays out of range.
    always_comb begin
        req_s    = pick_button(bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right);
        next_x_s = {1'b0, snake_x_q};
        next_y_s = {1'b0, snake_y_q};
        case (pending_q)
            DIR_RIGHT: next_x_s = {1'b0, snake_x_q} + STEP13;
            DIR_LEFT:  next_x_s = {1'b0, snake_x_q} - STEP13;
            DIR_UP:    next_y_s = {1'b0, snake_y_q} - STEP13;
            DIR_DOWN:  next_y_s = {1'b0, snake_y_q} + STEP13;
            default: begin
                next_x_s = {1'b0, snake_x_q};
                next_y_s = {1'b0, snake_y_q};
            end
        endcase
        legal_s = (next_x_s >= MIN_POS)
               && (({1'b0, next_x_s} + {1'b0, STEP13}) <= MAX_X_END)
               && (next_y_s >= MIN_POS)
               && (({1'b0, next_y_s} + {1'b0, STEP13}) <= MAX_Y_END);
    end

    // Game FSM with registered position and game_over.
    always_ff @(posedge CLOCK_50 or negedge fsm_rst_n_s) begin
        if (!fsm_rst_n_s) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_RIGHT;
            pending_q   <= DIR_RIGHT;
            snake_x_q   <= START_X;
            snake_y_q   <= START_Y;
            game_over_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s.valid) begin
                        state_q   <= ST_RUN;
                        dir_q     <= req_s.dir;
                        pending_q <= req_s.dir;
                    end
                end
                ST_RUN: begin
                    if (req_s.valid && (req_s.dir != reverse_dir(dir_q))) begin
                        pending_q <= req_s.dir;
                    end
                    // The move uses the pending value from before this edge.
                    if (tick_s) begin
                        dir_q <= pending_q;
                        if (legal_s) begin
                            snake_x_q <= next_x_s[11:0];
                            snake_y_q <= next_y_s[11:0];
                        end else begin
                            state_q     <= ST_DEAD;
                            game_over_q <= 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    state_q     <= ST_DEAD;
                    game_over_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Head pixel test against the current scan coordinate.
    always_comb begin
        inside_s = ({1'b0, bus.x} >= {1'b0, snake_x_q})
                && ({1'b0, bus.x} <  ({1'b0, snake_x_q} + STEP13))
                && ({1'b0, bus.y} >= {1'b0, snake_y_q})
                && ({1'b0, bus.y} <  ({1'b0, snake_y_q} + STEP13));
        if (inside_s) begin
            bus.vga_g = 8'hFF;
        end else begin
            bus.vga_g = 8'h00;
        end
        bus.vga_r = 8'h00;
        bus.vga_b = 8'h00;
    end

    assign bus.snake_x    = snake_x_q;
    assign bus.snake_y    = snake_y_q;
    assign bus.snake_size = 12'(STEP);
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_snake_head.sv
// Directed bench for snake_head with a scoreboard of expected values
// pushed at stimulus time and checked when the DUT result is due.
module tb_snake_head;

    logic clk;
    logic reset_n;

    snake_head_if bus ();

    snake_head #(
        .TICK_CYCLES   (20),
        .SPEEDUP_CYCLES(2),
        .MAX_LEVEL     (4)
    ) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    exp_q[$];
    string tag_q[$];

    task automatic sb_push(input string tag, input int value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic sb_check(input int observed);
        string tag;
        int    expected;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL sb_empty: got %0d required an expected entry", observed);
        end else begin
            tag      = tag_q.pop_front();
            expected = exp_q.pop_front();
            assert (observed === expected) n_pass++;
            else $error("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_buttons();
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        release_buttons();
        bus.score = 8'd0;
        bus.x     = 12'd0;
        bus.y     = 12'd0;
        step(2);
        reset_n = 1'b1;
        step(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        release_buttons();
        bus.score = 8'd0;
        bus.x     = 12'd0;
        bus.y     = 12'd0;
        do_reset();

        // Reset state
        sb_push("rst_x", 320);     sb_check(int'(bus.snake_x));
        sb_push("rst_y", 240);     sb_check(int'(bus.snake_y));
        sb_push("rst_go", 0);      sb_check(int'(bus.game_over));
        sb_push("rst_size", 10);   sb_check(int'(bus.snake_size));

        // Start moving right; first move exactly 20 clocks after RUN entry
        bus.btn_right = 1'b1;
        step(1);
        bus.btn_right = 1'b0;
        sb_push("start_x_19", 320); step(19); sb_check(int'(bus.snake_x));
        sb_push("start_x_20", 330); step(1);  sb_check(int'(bus.snake_x));
        sb_push("start_x_40", 340); step(20); sb_check(int'(bus.snake_x));
        sb_push("start_go", 0);     sb_check(int'(bus.game_over));

        // Reverse request is dropped
        bus.btn_left = 1'b1;
        step(1);
        bus.btn_left = 1'b0;
        sb_push("rev_x", 350); step(19); sb_check(int'(bus.snake_x));

        // Legal turn up
        bus.btn_up = 1'b1;
        step(1);
        bus.btn_up = 1'b0;
        sb_push("turn_y", 230); sb_push("turn_x", 350);
        step(19);
        sb_check(int'(bus.snake_y)); sb_check(int'(bus.snake_x));

        // Turn left from up
        bus.btn_left = 1'b1;
        step(1);
        bus.btn_left = 1'b0;
        sb_push("left_x", 340); sb_push("left_y", 230);
        step(19);
        sb_check(int'(bus.snake_x)); sb_check(int'(bus.snake_y));

        // Right wall from the centre
        do_reset();
        bus.btn_right = 1'b1;
        step(1);
        bus.btn_right = 1'b0;
        sb_push("wall29_x", 610); sb_push("wall29_go", 0);
        step(29 * 20);
        sb_check(int'(bus.snake_x)); sb_check(int'(bus.game_over));
        sb_push("wall30_x", 610); sb_push("wall30_go", 1);
        step(20);
        sb_check(int'(bus.snake_x)); sb_check(int'(bus.game_over));
        bus.btn_up = 1'b1;
        step(3);
        bus.btn_up = 1'b0;
        bus.btn_left = 1'b1;
        step(3);
        bus.btn_left = 1'b0;
        sb_push("dead_x", 610); sb_push("dead_y", 240); sb_push("dead_go", 1);
        step(40);
        sb_check(int'(bus.snake_x)); sb_check(int'(bus.snake_y));
        sb_check(int'(bus.game_over));

        // Speed-up: score 3 gives period 14; down beats right
        do_reset();
        bus.score     = 8'd3;
        bus.btn_down  = 1'b1;
        bus.btn_right = 1'b1;
        step(1);
        release_buttons();
        sb_push("spd3_y_13", 240); step(13); sb_check(int'(bus.snake_y));
        sb_push("spd3_y_14", 250); step(1);  sb_check(int'(bus.snake_y));
        sb_push("spd3_x", 320);    sb_check(int'(bus.snake_x));
        // Score 9 clamps to level 4: period 12
        bus.score = 8'd9;
        sb_push("spd9_y_11", 250); step(11); sb_check(int'(bus.snake_y));
        sb_push("spd9_y_12", 260); step(1);  sb_check(int'(bus.snake_y));

        // Pixel output around the head at (320, 260)
        bus.x = 12'd329; bus.y = 12'd260;
        #1;
        sb_push("pix_in_g", 255); sb_check(int'(bus.vga_g));
        sb_push("pix_in_r", 0);   sb_check(int'(bus.vga_r));
        sb_push("pix_in_b", 0);   sb_check(int'(bus.vga_b));
        bus.x = 12'd330;
        #1;
        sb_push("pix_xout_g", 0); sb_check(int'(bus.vga_g));
        bus.x = 12'd320; bus.y = 12'd269;
        #1;
        sb_push("pix_ylast_g", 255); sb_check(int'(bus.vga_g));
        bus.y = 12'd270;
        #1;
        sb_push("pix_yout_g", 0); sb_check(int'(bus.vga_g));

        // Asynchronous reset mid-run, away from any clock edge
        reset_n = 1'b0;
        #1;
        sb_push("areset_x", 320); sb_check(int'(bus.snake_x));
        sb_push("areset_y", 240); sb_check(int'(bus.snake_y));
        sb_push("areset_go", 0);  sb_check(int'(bus.game_over));
        step(2);
        reset_n = 1'b1;
        sb_push("idle_x", 320); sb_push("idle_y", 240);
        step(40);
        sb_check(int'(bus.snake_x)); sb_check(int'(bus.snake_y));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
